// File: rtl/ahblite_busmatrix_arbiter_rr_pkg.sv
// Bus-matrix common definitions shared by the output-stage arbiter and its
// burst tracker: AHB-Lite HTRANS/HBURST encodings, output-stage port codes
// and the burst-length-to-remaining-beats helper.
package ahblite_busmatrix_arbiter_rr_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_t;

   typedef enum logic [1:0] {
      PORT_NONE = 2'b00,
      PORT_SYS  = 2'b01,
      PORT_DMA  = 2'b10,
      PORT_ACC  = 2'b11
   } port_t;

   // Beats still to come after the NONSEQ of a burst of this type.
   function automatic logic [3:0] burst_beats_left(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  burst_beats_left = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  burst_beats_left = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: burst_beats_left = 4'd15;
         default:                      burst_beats_left = 4'd0;
      endcase
   endfunction

   // Request-vector bit for a port code: bit0 SYS, bit1 DMA, bit2 ACC.
   function automatic logic [2:0] port_onehot(input port_t p);
      case (p)
         PORT_SYS: port_onehot = 3'b001;
         PORT_DMA: port_onehot = 3'b010;
         PORT_ACC: port_onehot = 3'b100;
         default:  port_onehot = 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/ahblite_busmatrix_arbiter_rr_burst_tracker.sv
// Burst tracker for one output stage. Follows the muxed slave-side transfer
// stream and tells the arbiter when ownership must not move.
//   HCLK, HRESET        clock, async active-high reset
//   HREADY, HSEL        output-stage handshake / select
//   HTRANS, HBURST      output-stage muxed transfer type / burst type
//   acc                 transfer accepted this cycle
//   locked              owner must be kept at this edge
module ahblite_burst_tracker
   import ahblite_busmatrix_arbiter_rr_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       HREADY,
   input  logic       HSEL,
   input  logic [1:0] HTRANS,
   input  logic [2:0] HBURST,
   output logic       acc,
   output logic       locked
);

   logic [3:0] count, count_nxt;
   logic       incr_lock, incr_lock_nxt;

   always_comb begin
      acc           = HREADY & HSEL & HTRANS[1];
      count_nxt     = count;
      incr_lock_nxt = incr_lock;

      if (acc && HTRANS == HTRANS_NONSEQ)
         count_nxt = burst_beats_left(HBURST);
      else if (acc && HTRANS == HTRANS_SEQ && count != 4'd0)
         count_nxt = count - 4'd1;

      if (acc && HTRANS == HTRANS_NONSEQ && HBURST == HBURST_INCR)
         incr_lock_nxt = 1'b1;
      else if (HREADY && (HTRANS == HTRANS_IDLE || HTRANS == HTRANS_NONSEQ))
         incr_lock_nxt = 1'b0;

      // Judged on the post-edge view: the NONSEQ that opens a burst already
      // locks the owner, and the last SEQ beat releases it, so the grant can
      // move on the very edge that accepts the final beat.
      locked = (count_nxt != 4'd0) | incr_lock_nxt | (HTRANS == HTRANS_BUSY);
   end

   always_ff @(posedge HCLK or posedge HRESET)
      if (HRESET) begin
         count     <= 4'd0;
         incr_lock <= 1'b0;
      end else if (HREADY) begin
         count     <= count_nxt;
         incr_lock <= incr_lock_nxt;
      end

endmodule

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
// Registered round-robin (or fixed-priority) arbiter for one AHB-Lite
// bus-matrix output stage shared by SYS, DMA and ACC.
//   HCLK, HRESET                 clock, async active-high reset
//   REQ_SYS/REQ_DMA/REQ_ACC      per-master TRANS_HOLD & HSEL
//   HREADY, HSEL, HTRANS, HBURST muxed output-stage bus
//   PORT_SEL                     owner: 01 SYS, 10 DMA, 11 ACC
//   PORT_NOSEL                   1 = no owner, output stage drives idle
// Outputs come straight from flops, which breaks the mux->HTRANS->arbiter loop.
module ahblite_busmatrix_arbiter_rr
   import ahblite_busmatrix_arbiter_rr_pkg::*;
#(
   parameter int MAX_HOLD   = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       REQ_SYS,
   input  logic       REQ_DMA,
   input  logic       REQ_ACC,
   input  logic       HREADY,
   input  logic       HSEL,
   input  logic [1:0] HTRANS,
   input  logic [2:0] HBURST,
   output logic [1:0] PORT_SEL,
   output logic       PORT_NOSEL
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   port_t      port_q, port_d, rr_q, rr_d, pick;
   logic       nosel_q, nosel_d;
   logic [7:0] hold_q, hold_d, hold_inc;
   logic [2:0] req, owner_oh, cand;
   logic       acc, locked, others, own_req;

   ahblite_burst_tracker u_trk (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .HREADY (HREADY),
      .HSEL   (HSEL),
      .HTRANS (HTRANS),
      .HBURST (HBURST),
      .acc    (acc),
      .locked (locked)
   );

   // First requester strictly after the pointer in SYS->DMA->ACC order.
   function automatic port_t rr_pick(input logic [2:0] c, input port_t ptr);
      case (ptr)
         PORT_SYS: rr_pick = c[1] ? PORT_DMA : (c[2] ? PORT_ACC : PORT_SYS);
         PORT_DMA: rr_pick = c[2] ? PORT_ACC : (c[0] ? PORT_SYS : PORT_DMA);
         default:  rr_pick = c[0] ? PORT_SYS : (c[1] ? PORT_DMA : PORT_ACC);
      endcase
   endfunction

   function automatic port_t fixed_pick(input logic [2:0] c);
      fixed_pick = c[0] ? PORT_SYS : (c[1] ? PORT_DMA : PORT_ACC);
   endfunction

   always_comb begin
      req      = {REQ_ACC, REQ_DMA, REQ_SYS};
      owner_oh = nosel_q ? 3'b000 : port_onehot(port_q);
      others   = |(req & ~owner_oh);
      own_req  = |(req & owner_oh);
      // Tenure count including the transfer accepted on this edge.
      hold_inc = (acc && others && hold_q < HOLD_MAX) ? hold_q + 8'd1 : hold_q;
      // The current owner only competes when nobody else is asking; this also
      // keeps the tenure cap meaningful under fixed priority.
      cand     = others ? (req & ~owner_oh) : req;
      pick     = (FIXED_PRIO != 0) ? fixed_pick(cand) : rr_pick(cand, rr_q);

      port_d   = port_q;
      nosel_d  = nosel_q;
      rr_d     = rr_q;
      hold_d   = hold_q;

      if (HREADY) begin
         hold_d = others ? hold_inc : 8'd0;
         if (!locked) begin
            if (req == 3'b000) begin
               nosel_d = 1'b1;
               hold_d  = 8'd0;
            end else if (own_req && (MAX_HOLD == 0 || hold_inc < HOLD_MAX || !others)) begin
               port_d  = port_q;
            end else begin
               port_d  = pick;
               nosel_d = 1'b0;
               rr_d    = pick;
               if (nosel_q || pick != port_q)
                  hold_d = 8'd0;
            end
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET)
      if (HRESET) begin
         port_q  <= PORT_NONE;
         nosel_q <= 1'b1;
         rr_q    <= PORT_ACC;
         hold_q  <= 8'd0;
      end else begin
         port_q  <= port_d;
         nosel_q <= nosel_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
      end

   assign PORT_SEL   = port_q;
   assign PORT_NOSEL = nosel_q;

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_rr.sv
module tb_ahblite_busmatrix_arbiter_rr;

   localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
   localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b011, I8 = 3'b101;
   localparam logic [2:0] RS = 3'b001, RD = 3'b010, RA = 3'b100;

   logic       HCLK, HRESET, REQ_SYS, REQ_DMA, REQ_ACC, HREADY, HSEL;
   logic [1:0] HTRANS, PORT_SEL;
   logic [2:0] HBURST;
   logic       PORT_NOSEL;

   typedef struct {
      string      tag;
      logic [1:0] sel;
      logic       nosel;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   ahblite_busmatrix_arbiter_rr #(.MAX_HOLD(4), .FIXED_PRIO(0)) u_dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .REQ_SYS    (REQ_SYS),
      .REQ_DMA    (REQ_DMA),
      .REQ_ACC    (REQ_ACC),
      .HREADY     (HREADY),
      .HSEL       (HSEL),
      .HTRANS     (HTRANS),
      .HBURST     (HBURST),
      .PORT_SEL   (PORT_SEL),
      .PORT_NOSEL (PORT_NOSEL)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic push_exp(input logic [1:0] esel, input logic enosel, input string tag);
      exp_t e;
      e.tag = tag; e.sel = esel; e.nosel = enosel;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (PORT_SEL === e.sel && PORT_NOSEL === e.nosel) else begin
         errors++;
         $error("FAIL %s: got PORT_SEL=%b PORT_NOSEL=%b, want PORT_SEL=%b PORT_NOSEL=%b",
                e.tag, PORT_SEL, PORT_NOSEL, e.sel, e.nosel);
      end
   endtask

   // Drive one cycle on the falling edge, check the result 1 ns after the
   // following rising edge.
   task automatic step(input logic [2:0] req, input logic rdy, input logic sel,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic [1:0] esel, input logic enosel, input string tag);
      @(negedge HCLK);
      {REQ_ACC, REQ_DMA, REQ_SYS} = req;
      HREADY = rdy; HSEL = sel; HTRANS = tr; HBURST = bu;
      push_exp(esel, enosel, tag);
      @(posedge HCLK);
      #1;
      compare();
   endtask

   logic [1:0] rr_seq [5];
   logic [1:0] cap_seq [4];

   initial begin
      rr_seq[0] = 2'b11; rr_seq[1] = 2'b01; rr_seq[2] = 2'b10;
      rr_seq[3] = 2'b11; rr_seq[4] = 2'b01;
      cap_seq[0] = 2'b10; cap_seq[1] = 2'b10; cap_seq[2] = 2'b10; cap_seq[3] = 2'b01;

      HRESET = 1'b1;
      {REQ_ACC, REQ_DMA, REQ_SYS} = 3'b000;
      HREADY = 1'b1; HSEL = 1'b0; HTRANS = ID; HBURST = SGL;

      // Reset dominates even with traffic and requests present.
      step(3'b111, 1, 1, NS, I4, 2'b00, 1, "rst_hold0");
      step(3'b111, 1, 1, NS, I4, 2'b00, 1, "rst_hold1");
      HRESET = 1'b0;

      // First grant after reset, then idle with sel retained.
      step(RD, 1, 0, ID, SGL, 2'b10, 0, "first_grant_dma");
      step(3'b000, 1, 0, ID, SGL, 2'b10, 1, "idle_nosel_retain");
      step(RS, 1, 0, ID, SGL, 2'b01, 0, "grant_sys");

      // SYS INCR4 with DMA waiting; SYS request drops mid-burst.
      step(RS | RD, 1, 1, NS, I4, 2'b01, 0, "incr4_b1");
      step(RS | RD, 1, 1, SQ, I4, 2'b01, 0, "incr4_b2");
      step(RD,      1, 1, SQ, I4, 2'b01, 0, "incr4_b3_locked");
      step(RD,      1, 1, SQ, I4, 2'b10, 0, "incr4_b4_switch");

      // DMA INCR4 with three wait states mid-burst while ACC asks.
      step(RD, 1, 1, NS, I4, 2'b10, 0, "wait_b1");
      step(RD, 1, 1, SQ, I4, 2'b10, 0, "wait_b2");
      for (int i = 0; i < 3; i++)
         step(RA, 0, 1, SQ, I4, 2'b10, 0, "wait_frozen");
      step(RA, 1, 1, SQ, I4, 2'b10, 0, "wait_b3_locked");
      step(RA, 1, 1, SQ, I4, 2'b11, 0, "wait_b4_switch");

      // All requesters, SINGLE transfers: owner rotates every 4th transfer.
      for (int i = 0; i < 16; i++)
         step(3'b111, 1, 1, NS, SGL, rr_seq[(i + 1) / 4], 0, "rr_cycle");

      // Tenure cap: DMA singles with SYS pending.
      step(RD, 1, 0, ID, SGL, 2'b10, 0, "cap_grant_dma");
      for (int i = 0; i < 4; i++)
         step(RS | RD, 1, 1, NS, SGL, cap_seq[i], 0, "cap_hold");

      // Undefined-length INCR outlives the cap, released by IDLE.
      step(RS | RD, 1, 1, NS, INC, 2'b01, 0, "incr_ns");
      step(RS | RD, 1, 1, SQ, INC, 2'b01, 0, "incr_seq");
      step(RS | RD, 1, 1, SQ, INC, 2'b01, 0, "incr_seq");
      step(RS | RD, 1, 1, BZ, INC, 2'b01, 0, "incr_busy");
      step(RS | RD, 1, 1, SQ, INC, 2'b01, 0, "incr_seq");
      step(RS | RD, 1, 1, SQ, INC, 2'b01, 0, "incr_seq");
      step(RS | RD, 1, 0, ID, INC, 2'b10, 0, "incr_end_switch");

      // DMA INCR8, asynchronous reset in the middle of beat 5.
      step(RD, 1, 1, NS, I8, 2'b10, 0, "i8_b1");
      for (int i = 0; i < 3; i++)
         step(RD, 1, 1, SQ, I8, 2'b10, 0, "i8_seq");
      @(negedge HCLK);
      HTRANS = SQ;
      #2 HRESET = 1'b1;
      #1;
      push_exp(2'b00, 1, "async_rst");
      compare();
      step(3'b111, 1, 1, SQ, I8, 2'b00, 1, "rst_hold2");
      HRESET = 1'b0;

      // After release SYS goes first, then the pointer walks DMA, ACC.
      step(3'b111, 1, 0, ID, SGL, 2'b01, 0, "post_rst_sys");
      step(RD | RA, 1, 0, ID, SGL, 2'b10, 0, "next_dma");
      step(RA,      1, 0, ID, SGL, 2'b11, 0, "next_acc");
      step(3'b000,  1, 0, ID, SGL, 2'b11, 1, "final_nosel");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
